// File: rtl/fetch_sequencer_if.sv
// Decoder-facing bundle of the fetch sequencer.
// master = fetch side, slave = control decoder side.
interface fetch_sequencer_if #(
    parameter int PC_W = 9
);
    logic [1:0]      NextState;
    logic [8:0]      PrevInstructionIn;
    logic            BranchEn;
    logic [8:0]      BranchTarget;
    logic            AckIn;
    logic [PC_W-1:0] ProgCtr;
    logic [1:0]      CurrState;
    logic [8:0]      PrevInstruction;

    modport master (
        input  NextState,
        input  PrevInstructionIn,
        input  BranchEn,
        input  BranchTarget,
        input  AckIn,
        output ProgCtr,
        output CurrState,
        output PrevInstruction
    );

    modport slave (
        output NextState,
        output PrevInstructionIn,
        output BranchEn,
        output BranchTarget,
        output AckIn,
        input  ProgCtr,
        input  CurrState,
        input  PrevInstruction
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch/sequencing stage: owns PC, decoder mode and previous instruction,
// and runs the IDLE/ARM/RUN/DONE program lifecycle.
module fetch_sequencer #(
    parameter int              PC_W       = 9,
    parameter logic [PC_W-1:0] START_ADDR = '0,
    parameter int              CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    fetch_sequencer_if.master dec,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount,
    output logic             IllegalState
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [1:0]       cs_q, cs_d;
    logic [8:0]       pi_q, pi_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ill_q, ill_d;
    logic [PC_W-1:0]  tgt;

    assign tgt = PC_W'(dec.BranchTarget);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cs_d    = cs_q;
        pi_d    = pi_q;
        cnt_d   = cnt_q;
        ill_d   = ill_q;
        // Start overrides everything, from any state
        if (Start) begin
            state_d = ARM;
            pc_d    = START_ADDR;
            cs_d    = 2'b00;
            pi_d    = '0;
            cnt_d   = '0;
            ill_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                ARM:  state_d = RUN;
                RUN: begin
                    pi_d = dec.PrevInstructionIn;
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                    if (dec.AckIn) begin
                        state_d = DONE;
                        cs_d    = 2'b00;
                    end else begin
                        if (dec.BranchEn) pc_d = tgt;
                        else              pc_d = pc_q + PC_W'(1);
                        if (dec.NextState == 2'b11) begin
                            cs_d  = 2'b00;
                            ill_d = 1'b1;
                        end else begin
                            cs_d = dec.NextState;
                        end
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            pc_q    <= START_ADDR;
            cs_q    <= 2'b00;
            pi_q    <= '0;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cs_q    <= cs_d;
            pi_q    <= pi_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
        end
    end

    assign dec.ProgCtr         = pc_q;
    assign dec.CurrState       = cs_q;
    assign dec.PrevInstruction = pi_q;
    assign Running             = (state_q == RUN);
    assign Done                = (state_q == DONE);
    assign CycleCount          = cnt_q;
    assign IllegalState        = ill_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Fetch/sequencing stage directly upstream of the control decoder.
- Owns the program counter, the decoder's mode register (CurrState) and the previous-instruction register.
- Consumes the decoder's NextState, PrevInstructionOut, BranchEn, BranchTarget and Ack each cycle.
- Drives the instruction ROM address and reports program start, run and done status to the testbench or top level.

Parameters:
- PC_W, 9: program counter width; matches the 9-bit BranchTarget.
- START_ADDR, 0: PC value loaded while Start is asserted.
- CNT_W, 16: width of the run-cycle counter.

Ports:
- Clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-low reset; 0 forces reset values immediately.
- Start  input  1  level; high arms and holds the program at START_ADDR; falling edge begins execution.
- NextState  input  2  decoder's next mode (00 regular, 01 target, 10 immediate, 11 illegal).
- PrevInstructionIn  input  9  decoder's PrevInstructionOut (current instruction word).
- BranchEn  input  1  decoder branch-taken strobe.
- BranchTarget  input  9  decoder branch destination.
- AckIn  input  1  decoder "done" strobe.
- ProgCtr  output  PC_W  instruction ROM address.
- CurrState  output  2  registered mode, fed to the decoder.
- PrevInstruction  output  9  registered previous instruction, fed to the decoder.
- Running  output  1  high while in RUN.
- Done  output  1  high while in DONE.
- CycleCount  output  CNT_W  cycles spent in RUN; saturating.
- IllegalState  output  1  sticky; set when NextState==11 is seen in RUN.

Behaviour:
- Reset values: ProgCtr=START_ADDR, CurrState=00, PrevInstruction=0, Running=0, Done=0, CycleCount=0, IllegalState=0, FSM=IDLE.
- FSM states: IDLE, ARM, RUN, DONE. Running and Done decode directly from the registered FSM state.
- IDLE: Start=1 -> ARM. Otherwise hold.
- ARM, entered from any state when Start=1 (Start has top priority):
  - ProgCtr<=START_ADDR, CurrState<=00, PrevInstruction<=0, CycleCount<=0, IllegalState<=0.
  - Stays in ARM while Start=1; Start=0 -> RUN.
  - First instruction fetched is START_ADDR on the first RUN cycle.
- RUN, each cycle, priority order:
  1. AckIn=1 -> DONE. ProgCtr holds; CurrState<=00.
  2. BranchEn=1 -> ProgCtr<=BranchTarget, truncated or zero-extended to PC_W.
  3. Otherwise ProgCtr<=ProgCtr+1, wrapping modulo 2^PC_W (all-ones -> 0).
- RUN, every cycle including the Ack cycle:
  - PrevInstruction<=PrevInstructionIn.
  - CycleCount<=CycleCount+1, saturating at all-ones; the Ack cycle is counted.
- RUN, unless Ack:
  - CurrState<=NextState, except NextState==11: CurrState<=00 and IllegalState<=1.
- Target/immediate modes: the PC still advances by +1 in the cycle that fetches the operand word, so a two-word instruction takes 2 cycles. A branch resolved in target mode loads BranchTarget in that second cycle.
- DONE: all registers hold; CycleCount frozen; Start=1 -> ARM. Decoder inputs are ignored.
- IDLE, ARM and DONE: decoder inputs are ignored; CurrState is 00.
- Simultaneous events:
  - Start=1 with AckIn or BranchEn -> ARM wins.
  - AckIn with BranchEn -> Ack wins; the PC does not branch.
- Reset asserted mid-RUN: immediate return to reset values. After release, FSM=IDLE; Start is required to run again.
- Latency: decoder outputs take effect on ProgCtr, CurrState and PrevInstruction on the next rising edge (1 cycle).

Test Plan:
- Reset=0 then 1, Start pulse 3 cycles high then low, decoder idle (NextState=00, no branch) -> ProgCtr 0,1,2,3 on successive RUN cycles; Running=1; CycleCount=4 after 4 RUN cycles.
- In RUN at ProgCtr=5: NextState=01 with PrevInstructionIn=9'h180, next cycle BranchEn=1, BranchTarget=9'h020 -> ProgCtr 6 then 0x020; CurrState 01 then 00; PrevInstruction=0x180 during the target cycle.
- PC_W=9, ProgCtr=0x1FF, no branch -> ProgCtr=0x000. AckIn=1 with BranchEn=1, BranchTarget=0x040 at ProgCtr=0x010 -> Done=1, ProgCtr stays 0x010, CycleCount frozen.
- NextState=11 in RUN -> CurrState=00, IllegalState=1 and it stays 1. Start pulse -> IllegalState=0.
- Start=1 asserted mid-RUN at ProgCtr=0x33 -> next edge ProgCtr=0, Running=0, CycleCount=0. Reset=0 asserted mid-cycle -> outputs at reset values before the next clock edge.
- CNT_W=4, 20 RUN cycles without Ack -> CycleCount saturates at 15.
